// File: rtl/fetch_unit.sv
// Instruction fetch sequencer (IDLE/FETCH/HOLD) between instruction memory and the instruction register.
// Optional build macro FETCH_TIMEOUT_EN adds a 15-cycle memory-ack timeout with a sticky fetch_fault.
module fetch_unit #(
   parameter int                           ADDRESS_BUS_WIDTH = 16,
   parameter int                           INSTRUCTION_WIDTH = 32,
   parameter logic [ADDRESS_BUS_WIDTH-1:0] RESET_VECTOR      = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         run,
   input  logic                         stall,
   input  logic                         redirect,
   input  logic [ADDRESS_BUS_WIDTH-1:0] redirect_addr,
   output logic                         mem_req,
   output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
   input  logic                         mem_ack,
   input  logic [INSTRUCTION_WIDTH-1:0] mem_rdata,
   output logic [INSTRUCTION_WIDTH-1:0] inst_out,
   output logic [ADDRESS_BUS_WIDTH-1:0] inst_pc,
   output logic                         ir_en,
   output logic                         fetch_fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t                         state_reg;
   logic [ADDRESS_BUS_WIDTH-1:0]   pc_reg;
   logic [ADDRESS_BUS_WIDTH-1:0]   pend_addr_reg;
   logic                           pend_reg;
   logic [INSTRUCTION_WIDTH-1:0]   inst_reg;
   logic [ADDRESS_BUS_WIDTH-1:0]   inst_pc_reg;
   logic                           timeout;
   logic                           run_ok;

`ifdef FETCH_TIMEOUT_EN
   logic [3:0] to_cnt_reg;
   logic       fault_reg;

   // Fires on the 15th consecutive FETCH cycle without an ack.
   assign timeout     = (state_reg == FETCH) && !mem_ack && (to_cnt_reg == 4'd14);
   assign run_ok      = run && !fault_reg;
   assign fetch_fault = fault_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_reg <= 4'd0;
         fault_reg  <= 1'b0;
      end else if ((state_reg == FETCH) && !mem_ack) begin
         if (timeout) begin
            to_cnt_reg <= 4'd0;
            fault_reg  <= 1'b1;
         end else begin
            to_cnt_reg <= to_cnt_reg + 4'd1;
         end
      end else begin
         to_cnt_reg <= 4'd0;
      end
   end
`else
   assign timeout     = 1'b0;
   assign run_ok      = run;
   assign fetch_fault = 1'b0;
`endif

   assign mem_req  = (state_reg == FETCH);
   assign mem_addr = pc_reg;
   assign inst_out = inst_reg;
   assign inst_pc  = inst_pc_reg;
   // A redirect in HOLD discards the held word, so it must not be loaded that cycle.
   assign ir_en    = (state_reg == HOLD) && !stall && !redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         pc_reg        <= RESET_VECTOR;
         pend_reg      <= 1'b0;
         pend_addr_reg <= '0;
         inst_reg      <= '0;
         inst_pc_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (redirect)
                  pc_reg <= redirect_addr;
               if (run_ok)
                  state_reg <= FETCH;
            end
            FETCH: begin
               if (mem_ack) begin
                  if (redirect || pend_reg) begin
                     // Word fetched from the stale PC is dropped; a same-cycle redirect beats the latched one.
                     pc_reg    <= redirect ? redirect_addr : pend_addr_reg;
                     pend_reg  <= 1'b0;
                     state_reg <= run_ok ? FETCH : IDLE;
                  end else begin
                     inst_reg    <= mem_rdata;
                     inst_pc_reg <= pc_reg;
                     pc_reg      <= pc_reg + ADDRESS_BUS_WIDTH'(1);
                     state_reg   <= HOLD;
                  end
               end else if (timeout) begin
                  pend_reg  <= 1'b0;
                  state_reg <= IDLE;
               end else if (redirect) begin
                  pend_reg      <= 1'b1;
                  pend_addr_reg <= redirect_addr;
               end
            end
            HOLD: begin
               if (redirect) begin
                  pc_reg    <= redirect_addr;
                  state_reg <= run_ok ? FETCH : IDLE;
               end else if (!stall) begin
                  state_reg <= run_ok ? FETCH : IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic against a
// transaction-level model (outstanding fetch flag, held-instruction queue, pending-redirect queue).
module tb_fetch_unit;
   localparam int             AW = 16;
   localparam int             IW = 32;
   localparam logic [AW-1:0]  RV = '0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          run = 1'b0;
   logic          stall = 1'b0;
   logic          redirect = 1'b0;
   logic [AW-1:0] redirect_addr = '0;
   logic          mem_ack = 1'b0;
   logic [15:0]   tag = 16'hA5C3;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic [IW-1:0] mem_rdata;
   logic [IW-1:0] inst_out;
   logic [AW-1:0] inst_pc;
   logic          ir_en;
   logic          fetch_fault;

   int checks = 0;
   int failures = 0;

   // Memory returns a word tagged with the address it was read from.
   assign mem_rdata = {tag, mem_addr};

   always #5 clk = ~clk;

   fetch_unit #(
      .ADDRESS_BUS_WIDTH(AW),
      .INSTRUCTION_WIDTH(IW),
      .RESET_VECTOR(RV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .run(run),
      .stall(stall),
      .redirect(redirect),
      .redirect_addr(redirect_addr),
      .mem_req(mem_req),
      .mem_addr(mem_addr),
      .mem_ack(mem_ack),
      .mem_rdata(mem_rdata),
      .inst_out(inst_out),
      .inst_pc(inst_pc),
      .ir_en(ir_en),
      .fetch_fault(fetch_fault)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      logic [IW-1:0] d;
      logic [AW-1:0] pc;
   } ent_t;

   ent_t          held_q[$];
   logic [AW-1:0] pend_q[$];
   bit            busy = 1'b0;
   bit            m_fault = 1'b0;
   logic [AW-1:0] m_pc = RV;
   int            wait_cnt = 0;
`ifdef FETCH_TIMEOUT_EN
   localparam bit TIMEOUT_ON = 1'b1;
`else
   localparam bit TIMEOUT_ON = 1'b0;
`endif

   task automatic model_reset();
      held_q.delete();
      pend_q.delete();
      busy     = 1'b0;
      m_fault  = 1'b0;
      m_pc     = RV;
      wait_cnt = 0;
   endtask

   task automatic model_compare();
      chk("mem_req", mem_req, busy);
      if (busy)
         chk("mem_addr", mem_addr, m_pc);
      chk("ir_en", ir_en, (held_q.size() > 0) && !stall && !redirect);
      if (held_q.size() > 0) begin
         chk("inst_out", inst_out, held_q[0].d);
         chk("inst_pc", inst_pc, held_q[0].pc);
      end
      chk("fetch_fault", fetch_fault, m_fault);
   endtask

   task automatic model_step();
      if (busy) begin
         if (mem_ack) begin
            wait_cnt = 0;
            if (redirect || pend_q.size() > 0) begin
               m_pc = redirect ? redirect_addr : pend_q[$];
               pend_q.delete();
               busy = run;
            end else begin
               held_q.push_back('{d: mem_rdata, pc: m_pc});
               m_pc = m_pc + 1'b1;
               busy = 1'b0;
            end
         end else begin
            if (redirect)
               pend_q.push_back(redirect_addr);
            wait_cnt++;
            if (TIMEOUT_ON && wait_cnt == 15) begin
               m_fault  = 1'b1;
               busy     = 1'b0;
               wait_cnt = 0;
               pend_q.delete();
            end
         end
      end else if (held_q.size() > 0) begin
         if (redirect) begin
            held_q.delete();
            m_pc = redirect_addr;
            busy = run;
         end else if (!stall) begin
            held_q.delete();
            busy = run;
         end
      end else begin
         if (redirect)
            m_pc = redirect_addr;
         busy = run && !m_fault;
      end
   endtask

   always @(negedge clk) begin
      if (rst)
         model_reset();
      model_compare();
      if (!rst)
         model_step();
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (3) cyc();
      rst = 1'b0; run = 1'b1; mem_ack = 1'b1;
      @(negedge clk);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_ir_en", ir_en, 1'b0);
      chk("rst_inst_out", inst_out, 32'h0);
      chk("rst_inst_pc", inst_pc, 16'h0);
      chk("rst_mem_addr", mem_addr, RV);

      // Zero-wait stream: one instruction every two cycles.
      for (int k = 0; k < 4; k++) begin
         cyc();
         @(negedge clk);
         chk("seq_req", mem_req, 1'b1);
         chk("seq_addr", mem_addr, 16'(k));
         chk("seq_no_ir", ir_en, 1'b0);
         cyc();
         @(negedge clk);
         chk("seq_ir", ir_en, 1'b1);
         chk("seq_pc", inst_pc, 16'(k));
         chk("seq_data", inst_out, {16'hA5C3, 16'(k)});
      end

      // Stall holds the instruction for three cycles.
      cyc();
      @(negedge clk);
      chk("st_addr", mem_addr, 16'h0004);
      for (int k = 0; k < 3; k++) begin
         cyc();
         stall = 1'b1;
         @(negedge clk);
         chk("st_ir_low", ir_en, 1'b0);
         chk("st_data", inst_out, 32'hA5C3_0004);
      end
      cyc();
      stall = 1'b0; run = 1'b0;
      @(negedge clk);
      chk("st_ir_pulse", ir_en, 1'b1);
      chk("st_pc", inst_pc, 16'h0004);
      cyc();
      @(negedge clk);
      chk("st_ir_once", ir_en, 1'b0);
      chk("st_idle", mem_req, 1'b0);

      // Redirect during a waiting fetch of 0x0005.
      cyc();
      run = 1'b1; mem_ack = 1'b0;
      cyc();
      redirect = 1'b1; redirect_addr = 16'h0040;
      @(negedge clk);
      chk("rd_addr5", mem_addr, 16'h0005);
      cyc();
      redirect = 1'b0; mem_ack = 1'b1;
      @(negedge clk);
      chk("rd_stable", mem_addr, 16'h0005);
      chk("rd_no_ir", ir_en, 1'b0);
      cyc();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("rd_target", mem_addr, 16'h0040);
      chk("rd_req", mem_req, 1'b1);
      chk("rd_no_ir2", ir_en, 1'b0);
      cyc();
      mem_ack = 1'b1;
      cyc();
      @(negedge clk);
      chk("rd_ir", ir_en, 1'b1);
      chk("rd_pc", inst_pc, 16'h0040);

      // PC wrap from 0xFFFF.
      cyc();
      cyc();
      redirect = 1'b1; redirect_addr = 16'hFFFF;
      @(negedge clk);
      chk("wr_discard", ir_en, 1'b0);
      cyc();
      redirect = 1'b0;
      @(negedge clk);
      chk("wr_ffff", mem_addr, 16'hFFFF);
      cyc();
      @(negedge clk);
      chk("wr_pc", inst_pc, 16'hFFFF);
      cyc();
      @(negedge clk);
      chk("wr_zero", mem_addr, 16'h0000);
      cyc();
      mem_ack = 1'b0;
      @(negedge clk);
      chk("wr_pc0", inst_pc, 16'h0000);
      cyc();
      @(negedge clk);
      chk("wr_addr1", mem_addr, 16'h0001);

      // Asynchronous reset in the middle of a fetch.
      cyc();
      rst = 1'b1;
      #1;
      chk("ar_req_drop", mem_req, 1'b0);
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("ar_idle", mem_req, 1'b0);
      chk("ar_vec", mem_addr, RV);
      cyc();
      @(negedge clk);
      chk("ar_fetch", mem_req, 1'b1);
      chk("ar_fetch_addr", mem_addr, RV);

      // Memory never acknowledges.
      repeat (25) cyc();
      @(negedge clk);
`ifdef FETCH_TIMEOUT_EN
      chk("to_fault", fetch_fault, 1'b1);
      chk("to_req", mem_req, 1'b0);
`else
      chk("to_fault", fetch_fault, 1'b0);
      chk("to_req", mem_req, 1'b1);
`endif
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;

      // Randomized traffic checked by the model.
      for (int n = 0; n < 3000; n++) begin
         cyc();
         rst      = ($urandom_range(0, 249) == 0);
         run      = ($urandom_range(0, 9) != 0);
         stall    = ($urandom_range(0, 9) < 3);
         redirect = ($urandom_range(0, 9) == 0);
         redirect_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                                     : 16'($urandom);
         mem_ack  = ($urandom_range(0, 3) != 0);
         tag      = 16'($urandom);
      end
      cyc();
      rst = 1'b0; redirect = 1'b0;
      cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter ADDRESS_BUS_WIDTH, default 16, meaning program-counter and memory-address width.
REQ-002 The module SHALL have parameter INSTRUCTION_WIDTH, default 32, meaning fetched instruction word width.
REQ-003 The module SHALL have parameter RESET_VECTOR, default 0, meaning PC value loaded at reset.
REQ-004 The module SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst  input  1  meaning reset, asynchronous and active-high.
REQ-006 The module SHALL have port run  input  1  meaning fetching enabled.
REQ-007 The module SHALL have port stall  input  1  meaning the downstream instruction register cannot accept.
REQ-008 The module SHALL have ports redirect  input  1 and redirect_addr  input  ADDRESS_BUS_WIDTH, meaning a branch or jump target request.
REQ-009 The module SHALL have ports mem_req  output  1, mem_addr  output  ADDRESS_BUS_WIDTH, mem_ack  input  1 and mem_rdata  input  INSTRUCTION_WIDTH, forming the instruction memory handshake.
REQ-010 The module SHALL have ports inst_out  output  INSTRUCTION_WIDTH, inst_pc  output  ADDRESS_BUS_WIDTH and ir_en  output  1, which drive the instruction register's data input and load enable.
REQ-011 The module SHALL have port fetch_fault  output  1  meaning a memory timeout occurred (see Configuration).

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, FETCH and HOLD.
REQ-013 In IDLE: mem_req=0, ir_en=0; if run=1 then go to FETCH on the next edge.
REQ-014 In FETCH: mem_req=1 and mem_addr=pc; mem_addr SHALL stay stable until the cycle mem_ack=1.
REQ-015 FETCH with mem_ack=1 and no pending redirect: capture mem_rdata into inst_out, capture pc into inst_pc, set pc<=pc+1, go to HOLD.
REQ-016 In HOLD: ir_en=stall ? 0 : 1 (combinational); inst_out and inst_pc hold.
REQ-017 HOLD with stall=0: go to FETCH if run=1, else go to IDLE.
REQ-018 Latency: an ack in cycle N SHALL give inst_out valid and ir_en=1 in cycle N+1 when stall=0; back-to-back zero-wait fetches yield one instruction every 2 cycles.
REQ-019 The PC SHALL wrap modulo 2^ADDRESS_BUS_WIDTH (all-ones + 1 = 0).
REQ-020 redirect in IDLE or HOLD: pc<=redirect_addr, any held instruction is discarded, ir_en=0 that cycle, next state FETCH if run=1 else IDLE.
REQ-021 redirect in FETCH without ack: latch redirect_addr and set a pending flag; the in-flight handshake completes unchanged.
REQ-022 FETCH with ack and a pending flag, or ack and redirect in the same cycle: discard mem_rdata, pc<=latched or current redirect_addr (current wins), clear the flag, stay in FETCH (or go to IDLE if run=0).
REQ-023 run deasserted during FETCH: the handshake SHALL complete; the delivered instruction is presented in HOLD, then the FSM goes to IDLE.
REQ-024 mem_ack outside FETCH SHALL be ignored.

Reset
REQ-025 rst=1 SHALL immediately force state=IDLE, pc=RESET_VECTOR, mem_req=0, ir_en=0, inst_out=0, inst_pc=0, pending flag=0 and fetch_fault=0.
REQ-026 Reset during FETCH SHALL drop mem_req in the same cycle without waiting for an ack.

Configuration
REQ-027 Macro FETCH_TIMEOUT_EN defined: a 4-bit counter SHALL count consecutive FETCH cycles without ack and clear on ack or leaving FETCH.
REQ-028 When that counter reaches 15: fetch_fault=1 (sticky until rst), FSM goes to IDLE, and it ignores run until reset.
REQ-029 FETCH_TIMEOUT_EN undefined: no counter exists, fetch_fault SHALL be tied 0, and FETCH waits indefinitely.

Verification
REQ-030 Reset, then run=1 with mem_ack every cycle following req, and stall=0 -> mem_addr sequence 0,1,2,3; ir_en pulses every 2nd cycle; inst_pc matches each address.
REQ-031 Instruction acked, stall=1 for 3 cycles -> ir_en=0 for 3 cycles, inst_out stable; stall drops -> ir_en=1 for exactly 1 cycle.
REQ-032 redirect to 0x0040 while FETCH is waiting on address 0x0005 -> ack data discarded (no ir_en); next mem_addr=0x0040.
REQ-033 Set pc to 0xFFFF and fetch (16-bit address) -> next mem_addr=0x0000.
REQ-034 rst pulse mid-FETCH -> mem_req=0 in the same cycle; after release mem_addr=RESET_VECTOR.
REQ-035 With FETCH_TIMEOUT_EN and mem_ack held 0 -> fetch_fault=1 after 15 FETCH cycles, mem_req=0; without the macro -> mem_req stays 1 and fetch_fault=0.
